// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: state encoding and display constants.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int unsigned DIGIT_IDX_W = 2;
  localparam logic [3:0]  BCD_MAX     = 4'd9;
  localparam logic [3:0]  AN_RESET    = 4'b1110;

endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Modulo-DIV counter with enable and synchronous clear; tc marks the enabled terminal-count cycle.
module tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int unsigned W    = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  assign tc = en && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/clear FSM, tick prescaler with 9999 saturation,
// lap snapshot and multiplexed 4-digit display scan.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000000,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic       i_START_STOP,
  input  logic       i_LAP,
  input  logic       i_CLEAR,
  input  logic [3:0] i_DIGIT_1,
  input  logic [3:0] i_DIGIT_2,
  input  logic [3:0] i_DIGIT_3,
  input  logic [3:0] i_DIGIT_4,
  output logic       o_CNT_EN,
  output logic       o_CNT_CLR,
  output logic       o_RUNNING,
  output logic       o_OVF,
  output logic [3:0] o_AN,
  output logic [3:0] o_BCD
);

  state_t state, next_state;

  logic start_q, lap_q, clear_q;
  logic start_rise, lap_rise, clear_rise;
  logic tick_due, scan_step, saturated;
  logic cnt_en, ovf_set;
  logic ovf, cnt_clr, hold;
  logic [15:0] live, snap, disp;
  logic [DIGIT_IDX_W-1:0] idx;
  logic [3:0] an, bcd;

  // Edge-detect history resets high so a command held across reset release is not seen as new.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      start_q <= 1'b1;
      lap_q   <= 1'b1;
      clear_q <= 1'b1;
    end else begin
      start_q <= i_START_STOP;
      lap_q   <= i_LAP;
      clear_q <= i_CLEAR;
    end
  end

  assign start_rise = i_START_STOP & ~start_q;
  assign lap_rise   = i_LAP & ~lap_q;
  assign clear_rise = i_CLEAR & ~clear_q;

  tick_gen #(.DIV(TICK_DIV)) u_prescaler (
    .clk   (i_CLK),
    .rst_n (i_RST_N),
    .en    (state == ST_RUN),
    .clr   (clear_rise),
    .tc    (tick_due)
  );

  tick_gen #(.DIV(SCAN_DIV)) u_scan (
    .clk   (i_CLK),
    .rst_n (i_RST_N),
    .en    (1'b1),
    .clr   (1'b0),
    .tc    (scan_step)
  );

  assign live      = {i_DIGIT_1, i_DIGIT_2, i_DIGIT_3, i_DIGIT_4};
  assign saturated = (i_DIGIT_1 == BCD_MAX) && (i_DIGIT_2 == BCD_MAX) &&
                     (i_DIGIT_3 == BCD_MAX) && (i_DIGIT_4 == BCD_MAX);

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    cnt_en     = 1'b0;
    ovf_set    = 1'b0;
    if (clear_rise) begin
      next_state = ST_IDLE;
    end else begin
      if (start_rise && !ovf) begin
        unique case (state)
          ST_IDLE:  next_state = ST_RUN;
          ST_RUN:   next_state = ST_PAUSE;
          ST_PAUSE: next_state = ST_RUN;
          default:  next_state = ST_IDLE;
        endcase
      end
      // Saturation overrides any start/stop toggle in the same cycle.
      if (tick_due) begin
        if (saturated) begin
          ovf_set    = 1'b1;
          next_state = ST_PAUSE;
        end else begin
          cnt_en = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      cnt_clr <= 1'b0;
      ovf     <= 1'b0;
      hold    <= 1'b0;
      snap    <= '0;
    end else begin
      cnt_clr <= clear_rise;
      if (clear_rise) begin
        ovf  <= 1'b0;
        hold <= 1'b0;
      end else begin
        if (ovf_set) begin
          ovf <= 1'b1;
        end
        if (lap_rise) begin
          if (hold) begin
            hold <= 1'b0;
          end else if (state == ST_RUN) begin
            hold <= 1'b1;
            snap <= live;
          end
        end
      end
    end
  end

  assign disp = hold ? snap : live;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      idx <= '0;
      an  <= AN_RESET;
      bcd <= '0;
    end else begin
      if (scan_step) begin
        idx <= idx + 1'b1;
      end
      an  <= ~(4'b0001 << idx);
      bcd <= disp[{idx, 2'b00} +: 4];
    end
  end

  assign o_CNT_EN  = cnt_en;
  assign o_CNT_CLR = cnt_clr;
  assign o_RUNNING = (state == ST_RUN);
  assign o_OVF     = ovf;
  assign o_AN      = an;
  assign o_BCD     = bcd;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (TICK_DIV=4, SCAN_DIV=2): stimulus queues expected
// events/values per cycle, a negedge monitor pops and compares them.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int C_START  = 1;
  localparam int C_LAP    = 2;
  localparam int C_CLEAR  = 4;
  localparam int F_RUN = 0, F_OVF = 1, F_AN = 2, F_BCD = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, lap = 1'b0, clear = 1'b0;
  logic [3:0] d1 = 4'd0, d2 = 4'd0, d3 = 4'd0, d4 = 4'd0;
  logic cnt_en, cnt_clr, running, ovf;
  logic [3:0] an, bcd;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .i_CLK        (clk),
    .i_RST_N      (rst_n),
    .i_START_STOP (start),
    .i_LAP        (lap),
    .i_CLEAR      (clear),
    .i_DIGIT_1    (d1),
    .i_DIGIT_2    (d2),
    .i_DIGIT_3    (d3),
    .i_DIGIT_4    (d4),
    .o_CNT_EN     (cnt_en),
    .o_CNT_CLR    (cnt_clr),
    .o_RUNNING    (running),
    .o_OVF        (ovf),
    .o_AN         (an),
    .o_BCD        (bcd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int field;
    int val;
  } vchk_t;

  vchk_t vq[$];
  int    en_q[$];
  int    clr_q[$];
  int    checks = 0;
  int    errors = 0;
  int    c_r = 0;
  string fname[4] = '{"running", "ovf", "an", "bcd"};

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic void exp_val(int c, int f, int v);
    vq.push_back('{c, f, v});
  endfunction

  // First cycle >= c where o_AN shows 1110 (scan period 8 cycles, phase set by reset release).
  function automatic int an0_from(int c);
    int k = c;
    while ((((k - c_r - 1) % 8) + 8) % 8 > 1) k++;
    return k;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (cnt_en) begin
      if (en_q.size() == 0) check("cnt_en_unexpected", int'(cnt_en), 0);
      else check("cnt_en_cycle", cyc, en_q.pop_front());
    end else if (en_q.size() > 0 && en_q[0] <= cyc) begin
      void'(en_q.pop_front());
      check("cnt_en_missing", int'(cnt_en), 1);
    end
    if (cnt_clr) begin
      if (clr_q.size() == 0) check("cnt_clr_unexpected", int'(cnt_clr), 0);
      else check("cnt_clr_cycle", cyc, clr_q.pop_front());
    end else if (clr_q.size() > 0 && clr_q[0] <= cyc) begin
      void'(clr_q.pop_front());
      check("cnt_clr_missing", int'(cnt_clr), 1);
    end
    for (int i = vq.size() - 1; i >= 0; i--) begin
      if (vq[i].cyc == cyc) begin
        case (vq[i].field)
          F_RUN:   check(fname[F_RUN], int'(running), vq[i].val);
          F_OVF:   check(fname[F_OVF], int'(ovf), vq[i].val);
          F_AN:    check(fname[F_AN], int'(an), vq[i].val);
          default: check(fname[F_BCD], int'(bcd), vq[i].val);
        endcase
        vq.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic cmd(input int mask, input int c, input int width);
    wait_until(c);
    start = mask[0];
    lap   = mask[1];
    clear = mask[2];
    step(width);
    start = 1'b0;
    lap   = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, t, l, t2, x;
    int an_pat[8]  = '{14, 14, 13, 13, 11, 11, 7, 7};
    int bcd_pat[8] = '{4, 4, 3, 3, 2, 2, 1, 1};

    // Reset values and free-running scan with digits 1,2,3,4
    {d1, d2, d3, d4} = {4'd1, 4'd2, 4'd3, 4'd4};
    step(3);
    c_r = cyc;
    exp_val(c_r, F_RUN, 0);
    exp_val(c_r, F_OVF, 0);
    exp_val(c_r, F_AN, 14);
    exp_val(c_r, F_BCD, 0);
    for (int k = 0; k < 8; k++) begin
      exp_val(c_r + 1 + k, F_AN, an_pat[k]);
      exp_val(c_r + 1 + k, F_BCD, bcd_pat[k]);
    end
    rst_n = 1'b1;
    wait_until(c_r + 10);

    // Start: running from +1, ticks at +4, +8, +12; clear at +13
    c0 = cyc;
    exp_val(c0, F_RUN, 0);
    exp_val(c0 + 1, F_RUN, 1);
    exp_val(c0 + 12, F_RUN, 1);
    en_q.push_back(c0 + 4);
    en_q.push_back(c0 + 8);
    en_q.push_back(c0 + 12);
    clr_q.push_back(c0 + 14);
    exp_val(c0 + 14, F_RUN, 0);
    cmd(C_START, c0, 1);
    cmd(C_CLEAR, c0 + 13, 1);
    wait_until(c0 + 18);

    // Pause holds prescaler: start 0, stop 6, start 10 -> ticks at 4 and 12
    c0 = cyc;
    en_q.push_back(c0 + 4);
    en_q.push_back(c0 + 12);
    exp_val(c0 + 6, F_RUN, 1);
    exp_val(c0 + 7, F_RUN, 0);
    exp_val(c0 + 10, F_RUN, 0);
    exp_val(c0 + 11, F_RUN, 1);
    clr_q.push_back(c0 + 14);
    cmd(C_START, c0, 1);
    cmd(C_START, c0 + 6, 1);
    cmd(C_START, c0 + 10, 1);
    cmd(C_CLEAR, c0 + 13, 1);
    wait_until(c0 + 18);

    // Lap hold: snapshot 0,0,1,2 shown while live moves to 0,0,1,5
    {d1, d2, d3, d4} = {4'd0, 4'd0, 4'd1, 4'd2};
    c0 = cyc;
    t  = an0_from(c0 + 5);
    l  = t + 1;
    t2 = an0_from(l + 2);
    x  = t2 + 1;
    if ((x - c0) % TICK_DIV == 0) x++;
    for (int c = c0 + 4; c < x; c += TICK_DIV) en_q.push_back(c);
    exp_val(t, F_BCD, 2);
    exp_val(t, F_RUN, 1);
    exp_val(t2, F_BCD, 5);
    clr_q.push_back(x + 1);
    cmd(C_START, c0, 1);
    cmd(C_LAP, c0 + 2, 1);
    d4 = 4'd5;
    cmd(C_LAP, l, 1);
    cmd(C_CLEAR, x, 1);
    wait_until(x + 4);

    // Saturation at 9999: no tick, overflow, pause, start ignored, clear recovers
    {d1, d2, d3, d4} = {4'd9, 4'd9, 4'd9, 4'd9};
    c0 = cyc;
    exp_val(c0 + 4, F_RUN, 1);
    exp_val(c0 + 4, F_OVF, 0);
    exp_val(c0 + 5, F_RUN, 0);
    exp_val(c0 + 5, F_OVF, 1);
    exp_val(c0 + 8, F_RUN, 0);
    exp_val(c0 + 8, F_OVF, 1);
    clr_q.push_back(c0 + 10);
    exp_val(c0 + 10, F_OVF, 0);
    exp_val(c0 + 12, F_RUN, 1);
    en_q.push_back(c0 + 15);
    clr_q.push_back(c0 + 18);
    cmd(C_START, c0, 1);
    cmd(C_START, c0 + 6, 1);
    cmd(C_CLEAR, c0 + 9, 1);
    {d1, d2, d3, d4} = '0;
    cmd(C_START, c0 + 11, 1);
    cmd(C_CLEAR, c0 + 17, 1);
    wait_until(c0 + 20);

    // Long start pulse toggles once; clear+start together -> idle, no further ticks
    c0 = cyc;
    exp_val(c0 + 3, F_RUN, 1);
    exp_val(c0 + 5, F_RUN, 1);
    en_q.push_back(c0 + 4);
    clr_q.push_back(c0 + 7);
    exp_val(c0 + 7, F_RUN, 0);
    exp_val(c0 + 12, F_RUN, 0);
    cmd(C_START, c0, 3);
    cmd(C_START | C_CLEAR, c0 + 6, 1);
    wait_until(c0 + 14);

    // Reset mid-run with start held across release: no pending tick, no command honoured
    c0 = cyc;
    exp_val(c0 + 3, F_RUN, 0);
    exp_val(c0 + 6, F_AN, 14);
    exp_val(c0 + 7, F_RUN, 0);
    exp_val(c0 + 8, F_RUN, 0);
    exp_val(c0 + 10, F_RUN, 0);
    cmd(C_START, c0, 1);
    wait_until(c0 + 3);
    rst_n = 1'b0;
    start = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(2);
    start = 1'b0;
    wait_until(c0 + 12);

    check("en_queue_drained", en_q.size(), 0);
    check("clr_queue_drained", clr_q.size(), 0);
    check("val_queue_drained", vq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
